// File: rtl/addaccu_seq_if.sv
// ---------------------------------------------------------------------------
// addaccu_seq_if
// Bundle of the job sequencer's handshake and datapath-drive signals.
//   start_*      : job request channel (valid/ready, operand count)
//   op_*         : operand stream channel (valid/ready, 4-bit data)
//   res_*        : result channel (valid/ready, low nibble + carry count)
//   busy         : sequencer is not idle
//   acc_sel/a/b  : drive into the 4-bit adder-accumulator datapath
//   acc_sum/carry: combinational result back from the datapath
// Modport slave is the sequencer; modport master is the requester plus
// datapath side.
// ---------------------------------------------------------------------------
interface addaccu_seq_if #(
    parameter int CNT_W = 5
);
    logic             start_valid;
    logic             start_ready;
    logic [CNT_W-1:0] start_n;
    logic             op_valid;
    logic             op_ready;
    logic [3:0]       op_data;
    logic             res_valid;
    logic             res_ready;
    logic [3:0]       res_sum;
    logic [CNT_W-1:0] res_carries;
    logic             busy;
    logic             acc_sel;
    logic [3:0]       acc_a;
    logic [3:0]       acc_b;
    logic [3:0]       acc_sum;
    logic             acc_carry;

    modport slave (
        input  start_valid, start_n, op_valid, op_data, res_ready,
               acc_sum, acc_carry,
        output start_ready, op_ready, res_valid, res_sum, res_carries,
               busy, acc_sel, acc_a, acc_b
    );

    modport master (
        output start_valid, start_n, op_valid, op_data, res_ready,
               acc_sum, acc_carry,
        input  start_ready, op_ready, res_valid, res_sum, res_carries,
               busy, acc_sel, acc_a, acc_b
    );
endinterface

// File: rtl/addaccu_seq.sv
// ---------------------------------------------------------------------------
// addaccu_seq
// Job sequencer for a 4-bit adder-accumulator datapath. Accepts a job of N
// operands, streams them into the datapath (clear on the first, accumulate on
// the rest), counts carry-outs and reports total = res_carries*16 + res_sum.
// Ports:
//   ck   : clock, all logic on posedge
//   rst  : synchronous, active-high reset
//   bus  : addaccu_seq_if.slave (start/op/res handshakes, datapath drive)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a job request (start_ready=1)
// FIRST | waiting for the first operand; its transfer clears the datapath
// ACCUM | waiting for further operands; each transfer accumulates
// DONE  | result presented (res_valid=1) until res_ready
// ---------------------------------------------------------------------------
module addaccu_seq #(
    parameter int CNT_W = 5
) (
    input  logic         ck,
    input  logic         rst,
    addaccu_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic             start_ready_q;
    logic             op_ready_q;
    logic             res_valid_q;
    logic             busy_q;
    logic [3:0]       res_sum_q;
    logic [CNT_W-1:0] res_car_q;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] carry_cnt;
    logic [CNT_W-1:0] carry_inc;
    logic             op_xfer;
    logic             acc_sel_c;
    logic [3:0]       acc_b_c;

    // op_ready_q is only ever set in FIRST/ACCUM, so it doubles as the
    // "operand phase" qualifier for the transfer.
    assign op_xfer   = op_ready_q & bus.op_valid;
    assign carry_inc = carry_cnt + {{(CNT_W-1){1'b0}}, bus.acc_carry};

    always_ff @(posedge ck) begin
        if (rst) begin
            state         <= IDLE;
            start_ready_q <= 1'b0;
            op_ready_q    <= 1'b0;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            res_sum_q     <= 4'd0;
            res_car_q     <= '0;
            remaining     <= '0;
            carry_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    start_ready_q <= 1'b1;
                    if (bus.start_valid && start_ready_q) begin
                        start_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                        if (bus.start_n != '0) begin
                            remaining  <= bus.start_n;
                            carry_cnt  <= '0;
                            op_ready_q <= 1'b1;
                            state      <= FIRST;
                        end else begin
                            // Empty job: report zero without touching the datapath.
                            res_sum_q   <= 4'd0;
                            res_car_q   <= '0;
                            res_valid_q <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                FIRST, ACCUM: begin
                    if (op_xfer) begin
                        remaining <= remaining - 1'b1;
                        carry_cnt <= carry_inc;
                        state     <= ACCUM;
                        if (remaining == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                            // Datapath result of this very transfer is final.
                            res_sum_q   <= bus.acc_sum;
                            res_car_q   <= carry_inc;
                            op_ready_q  <= 1'b0;
                            res_valid_q <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        res_valid_q   <= 1'b0;
                        busy_q        <= 1'b0;
                        start_ready_q <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Hold (sel=1, b=0) unless an operand is transferring this cycle.
    always_comb begin
        acc_sel_c = 1'b1;
        acc_b_c   = 4'd0;
        if (!rst && op_xfer) begin
            acc_b_c   = bus.op_data;
            acc_sel_c = (state != FIRST);
        end
    end

    assign bus.start_ready = start_ready_q;
    assign bus.op_ready    = op_ready_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_sum     = res_sum_q;
    assign bus.res_carries = res_car_q;
    assign bus.busy        = busy_q;
    assign bus.acc_sel     = acc_sel_c;
    assign bus.acc_a       = 4'd0;
    assign bus.acc_b       = acc_b_c;
endmodule

// File: tb/tb_addaccu_seq.sv
// ---------------------------------------------------------------------------
// tb_addaccu_seq
// Bench for addaccu_seq: a behavioural 4-bit adder-accumulator datapath,
// a table of directed jobs, hand-written reset/abort sequence and random
// jobs checked against the arithmetic total (sum mod 16, sum div 16).
// ---------------------------------------------------------------------------
module tb_addaccu_seq;
    localparam int CNT_W = 5;

    logic ck;
    logic rst;
    int   vectors;
    int   miscompares;

    addaccu_seq_if #(.CNT_W(CNT_W)) bus ();

    addaccu_seq #(.CNT_W(CNT_W)) dut (
        .ck  (ck),
        .rst (rst),
        .bus (bus)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Datapath: register loads (sel ? reg : a) + b on every edge.
    logic [3:0] dp_reg;
    logic [4:0] dp_full;
    always_comb dp_full = (bus.acc_sel ? {1'b0, dp_reg} : {1'b0, bus.acc_a})
                          + {1'b0, bus.acc_b};
    assign bus.acc_sum   = dp_full[3:0];
    assign bus.acc_carry = dp_full[4];
    always_ff @(posedge ck) dp_reg <= dp_full[3:0];

    typedef struct {
        int           n;
        logic [127:0] ops;
        int           bub_at;
        int           bub_len;
        int           hold;
        logic [3:0]   exp_sum;
        logic [4:0]   exp_car;
    } vec_t;

    vec_t tbl[6];

    task automatic step();
        @(posedge ck);
        @(negedge ck);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_start_ready"}, 32'(bus.start_ready), 0);
        chk({tag, "_op_ready"},    32'(bus.op_ready), 0);
        chk({tag, "_res_valid"},   32'(bus.res_valid), 0);
        chk({tag, "_res_sum"},     32'(bus.res_sum), 0);
        chk({tag, "_res_carries"}, 32'(bus.res_carries), 0);
        chk({tag, "_busy"},        32'(bus.busy), 0);
        chk({tag, "_acc_sel"},     32'(bus.acc_sel), 1);
        chk({tag, "_acc_a"},       32'(bus.acc_a), 0);
        chk({tag, "_acc_b"},       32'(bus.acc_b), 0);
    endtask

    task automatic run_job(input int n, input logic [127:0] ops, input int bub_at,
                           input int bub_len, input int hold,
                           input logic [3:0] es, input logic [4:0] ec);
        int         t;
        logic [3:0] held;
        logic [3:0] d;
        t = 0;
        while (!bus.start_ready && t < 20) begin
            step();
            t++;
        end
        chk("start_ready_wait", 32'(bus.start_ready), 1);
        bus.start_valid = 1'b1;
        bus.start_n     = n[CNT_W-1:0];
        step();
        bus.start_valid = 1'b0;
        chk("busy_in_job", 32'(bus.busy), 1);
        if (n == 0) begin
            chk("n0_op_ready", 32'(bus.op_ready), 0);
            chk("n0_acc_sel", 32'(bus.acc_sel), 1);
        end
        for (int i = 0; i < n; i++) begin
            if (i == bub_at) begin
                for (int k = 0; k < bub_len; k++) begin
                    bus.op_valid = 1'b0;
                    #1;
                    held = bus.acc_sum;
                    chk("bubble_acc_sel", 32'(bus.acc_sel), 1);
                    chk("bubble_acc_b", 32'(bus.acc_b), 0);
                    step();
                    chk("bubble_acc_sum", 32'(bus.acc_sum), 32'(held));
                end
            end
            d            = ops[4*i +: 4];
            bus.op_valid = 1'b1;
            bus.op_data  = d;
            t = 0;
            while (!bus.op_ready && t < 20) begin
                step();
                t++;
            end
            chk("op_ready", 32'(bus.op_ready), 1);
            #1;
            chk("xfer_acc_sel", 32'(bus.acc_sel), (i == 0) ? 0 : 1);
            chk("xfer_acc_b", 32'(bus.acc_b), 32'(d));
            step();
            bus.op_valid = 1'b0;
        end
        // One cycle after the last transfer (or after accept for N=0).
        chk("res_valid_latency", 32'(bus.res_valid), 1);
        chk("res_sum", 32'(bus.res_sum), 32'(es));
        chk("res_carries", 32'(bus.res_carries), 32'(ec));
        for (int h = 0; h < hold; h++) begin
            bus.start_valid = 1'b1;
            bus.op_valid    = 1'b1;
            bus.res_ready   = 1'b0;
            step();
            chk("hold_res_valid", 32'(bus.res_valid), 1);
            chk("hold_res_sum", 32'(bus.res_sum), 32'(es));
            chk("hold_res_carries", 32'(bus.res_carries), 32'(ec));
            chk("hold_start_ready", 32'(bus.start_ready), 0);
            chk("hold_op_ready", 32'(bus.op_ready), 0);
            chk("hold_acc_sel", 32'(bus.acc_sel), 1);
        end
        bus.start_valid = 1'b0;
        bus.op_valid    = 1'b0;
        bus.res_ready   = 1'b1;
        step();
        bus.res_ready = 1'b0;
        chk("after_res_valid", 32'(bus.res_valid), 0);
        chk("after_start_ready", 32'(bus.start_ready), 1);
        chk("after_busy", 32'(bus.busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;

        tbl[0] = '{n: 3,  ops: 128'h765,  bub_at: -1, bub_len: 0, hold: 0, exp_sum: 4'd2,  exp_car: 5'd1};
        tbl[1] = '{n: 1,  ops: 128'h9,    bub_at: -1, bub_len: 0, hold: 0, exp_sum: 4'd9,  exp_car: 5'd0};
        tbl[2] = '{n: 1,  ops: 128'hF,    bub_at: -1, bub_len: 0, hold: 0, exp_sum: 4'd15, exp_car: 5'd0};
        tbl[3] = '{n: 16, ops: {64'h0, 64'hFFFF_FFFF_FFFF_FFFF}, bub_at: 4, bub_len: 3, hold: 0,
                   exp_sum: 4'd0, exp_car: 5'd15};
        tbl[4] = '{n: 0,  ops: 128'h0,    bub_at: -1, bub_len: 0, hold: 0, exp_sum: 4'd0,  exp_car: 5'd0};
        tbl[5] = '{n: 2,  ops: 128'h21,   bub_at: -1, bub_len: 0, hold: 5, exp_sum: 4'd3,  exp_car: 5'd0};

        rst             = 1'b1;
        bus.start_valid = 1'b0;
        bus.start_n     = '0;
        bus.op_valid    = 1'b0;
        bus.op_data     = 4'd0;
        bus.res_ready   = 1'b0;
        step();
        step();
        chk_reset_vals("reset");
        rst = 1'b0;

        for (int v = 0; v < 6; v++)
            run_job(tbl[v].n, tbl[v].ops, tbl[v].bub_at, tbl[v].bub_len, tbl[v].hold,
                    tbl[v].exp_sum, tbl[v].exp_car);

        // Abort: reset after the 2nd of 4 operands.
        begin
            int t;
            t = 0;
            while (!bus.start_ready && t < 20) begin
                step();
                t++;
            end
            chk("abort_start_ready", 32'(bus.start_ready), 1);
            bus.start_valid = 1'b1;
            bus.start_n     = 5'd4;
            step();
            bus.start_valid = 1'b0;
            for (int i = 0; i < 2; i++) begin
                bus.op_valid = 1'b1;
                bus.op_data  = 4'(i + 8);
                step();
            end
            bus.op_data = 4'd5;
            rst         = 1'b1;
            step();
            rst = 1'b0;
            chk_reset_vals("abort");
            bus.op_valid = 1'b0;
            for (int i = 0; i < 3; i++) begin
                step();
                chk("abort_no_res_valid", 32'(bus.res_valid), 0);
            end
            run_job(2, 128'h43, -1, 0, 0, 4'd7, 5'd0);
        end

        // Random jobs against the arithmetic total.
        for (int j = 0; j < 24; j++) begin
            int           n;
            int           total;
            logic [127:0] ops;
            n     = int'($urandom_range(0, 31));
            ops   = {$urandom, $urandom, $urandom, $urandom};
            total = 0;
            for (int i = 0; i < n; i++) total += int'(ops[4*i +: 4]);
            run_job(n, ops, int'($urandom_range(0, 31)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 2)), total[3:0], total[8:4]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
